csr_trap_ctrl: RTL and testbench
================================

# csr_trap_ctrl

Sequencer and arbiter for the single access port of `CSR_regfile`. It shares the port between CSR instructions from the pipeline and its own multi-cycle trap-entry and `mret` sequences. Trap entry writes mepc/mcause/mtval, updates mstatus, then reads mtvec. `mret` restores mstatus and reads mepc. Both sequences end by issuing one PC redirect to the fetch stage. The block sits between the execute stage and the CSR register file and stalls the pipeline while a sequence runs.

## Interface
Parameters:
- `DW`, default `` `REG_WIDTH ``: CSR data width.

Ports:
- `clk_sys_i`, in, 1: system clock; all state changes on its rising edge.
- `rst_sys_n_i`, in, 1: reset, synchronous, active-low.
- `inst_csr_req_i`, in, 1: pipeline CSR access request; held until granted.
- `inst_csr_addr_i`, in, 12: instruction CSR address.
- `inst_csr_we_i`, in, 1: instruction write enable.
- `inst_csr_wdata_i`, in, DW: instruction write data.
- `inst_csr_gnt_o`, out, 1: grant; access takes effect at this clock edge.
- `inst_csr_rdata_o`, out, DW: read data, valid in the grant cycle.
- `inst_csr_illegal_o`, out, 1: write to a read-only CSR attempted, valid in the grant cycle.
- `trap_req_i`, in, 1: trap request; held until `trap_ack_o`.
- `trap_cause_i`, in, DW: mcause value; MSB set marks an interrupt.
- `trap_pc_i`, in, DW: PC of the faulting or interrupted instruction.
- `trap_tval_i`, in, DW: mtval value.
- `mret_req_i`, in, 1: `mret` request; held until `mret_ack_o`.
- `trap_ack_o`, out, 1: trap accepted; 1-cycle pulse.
- `mret_ack_o`, out, 1: `mret` accepted; 1-cycle pulse.
- `csr_addr_o`, out, 12: address driven to the regfile.
- `csr_write_ena_o`, out, 1: regfile write enable.
- `csr_wdata_o`, out, DW: regfile write data.
- `csr_rdata_i`, in, DW: combinational regfile read data for `csr_addr_o`.
- `busy_o`, out, 1: sequence in progress; pipeline stalls.
- `redirect_valid_o`, out, 1: registered 1-cycle pulse to fetch.
- `redirect_pc_o`, out, DW: redirect target; holds its last value.

## Operation
- States:
  - IDLE
  - T_EPC, T_CAUSE, T_TVAL, T_STAT, T_VEC (trap entry)
  - R_STAT, R_EPC (`mret`)
- IDLE arbitration, fixed priority: trap > `mret` > instruction.
  - `trap_ack_o` = `trap_req_i` in IDLE.
  - `mret_ack_o` = `mret_req_i` and not `trap_req_i`, in IDLE.
  - `inst_csr_gnt_o` = `inst_csr_req_i`, in IDLE, with neither trap nor `mret` requested.
- Instruction access: `csr_addr_o` = `inst_csr_addr_i` and `inst_csr_rdata_o` = `csr_rdata_i`.
  - Write enable = `inst_csr_we_i` and `addr[11:10]` != 2'b11.
  - A blocked write still grants and pulses `inst_csr_illegal_o`.
- Trap payload (cause, pc, tval) is captured in internal registers at `trap_ack_o`.
- Trap sequence, one state per cycle:
  - T_EPC: write mepc = {pc[DW-1:2], 2'b00}.
  - T_CAUSE: write mcause.
  - T_TVAL: write mtval.
  - T_STAT: read-modify-write mstatus in one cycle: MPIE ← MIE, MIE ← 0, MPP ← 2'b11, other bits from `csr_rdata_i`.
  - T_VEC: read mtvec and register the target → IDLE.
- `mret` sequence:
  - R_STAT: mstatus MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
  - R_EPC: read mepc and register it as the target → IDLE.
- Outside IDLE, no request is acknowledged or granted; `busy_o` = (state != IDLE).
- In IDLE with no grant, `csr_addr_o` = `inst_csr_addr_i` and `csr_write_ena_o` = 0.

## Timing
- Reset values:
  - State = IDLE.
  - `redirect_valid_o` = 0 and `redirect_pc_o` = 0.
  - All acks, grants and `csr_write_ena_o` = 0; `busy_o` = 0.
- Trap acknowledged at edge 0:
  - States T_EPC..T_VEC occupy cycles 1–5.
  - `redirect_valid_o` is high in cycle 6, with the controller back in IDLE.
  - A new request may be acknowledged in cycle 6.
- `mret` acknowledged at edge 0: R_STAT in cycle 1, R_EPC in cycle 2, redirect in cycle 3.
- Instruction access has zero added latency: grant, read data and write are all in the same cycle.
- Simultaneous trap, `mret` and instruction requests: trap wins; the others stay pending and are served after return to IDLE.
- Reset mid-sequence: return to IDLE next cycle with no redirect. CSR writes already done are not undone.

## Configuration
- `QT_VECTORED_TRAP_EN` defined:
  - mtvec[1:0] = 2'b01 and cause MSB = 1 → target = {mtvec[DW-1:2], 2'b00} + (cause[DW-2:0] << 2).
  - Otherwise target = base.
- Undefined: mode bits are ignored and target = {mtvec[DW-1:2], 2'b00} always.

## Structure
- Shared header `QianTang_header.v` holds:
  - CSR address constants: MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342, MTVAL 12'h343.
  - mstatus bit positions: MIE 3, MPIE 7, MPP 12:11.
  - State encodings.
- One sub-module: `csr_trap_target`, a combinational mtvec/cause → target computation containing the `QT_VECTORED_TRAP_EN` logic.

## Test plan
- Instruction write to 12'h341 with data 0x80 → granted the same cycle, mepc reads back 0x80; write to 12'hF14 → `inst_csr_illegal_o` = 1, no write.
- Trap with cause 2, pc 0x1002, tval 0xDEAD, mtvec 0x100, mstatus.MIE = 1 → mepc 0x1000, mcause 2, mtval 0xDEAD, MIE 0, MPIE 1, MPP 3; redirect 0x100 in cycle 6.
- `mret` after the trap → MIE 1, MPIE 1; redirect 0x1000 in cycle 3.
- Same-cycle trap, `mret` and instruction requests → only `trap_ack_o`; `mret_ack_o` in cycle 6; grant after the `mret` completes.
- Vectored case, mtvec 0x201 with cause 0x8…07 → target 0x21C with the macro defined, 0x200 without.
- Reset asserted in T_TVAL → IDLE next cycle, no redirect, mtval unchanged, mepc/mcause already written.

Source files
------------

// File: rtl/csr_trap_ctrl_pkg.sv
// csr_trap_ctrl_pkg: CSR addresses, mstatus bit positions and sequencer
// state encodings shared by the trap/mret controller and its target logic.
package csr_trap_ctrl_pkg;

    // Machine-mode CSR addresses touched by the hardware sequences
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // mstatus field positions
    localparam int MSTATUS_MIE     = 3;
    localparam int MSTATUS_MPIE    = 7;
    localparam int MSTATUS_MPP_LO  = 11;
    localparam int MSTATUS_MPP_HI  = 12;

    // Sequencer states: IDLE arbitrates, T_* is trap entry, R_* is mret
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_T_EPC  = 3'd1,
        ST_T_CAUSE= 3'd2,
        ST_T_TVAL = 3'd3,
        ST_T_STAT = 3'd4,
        ST_T_VEC  = 3'd5,
        ST_R_STAT = 3'd6,
        ST_R_EPC  = 3'd7
    } state_t;

    // Addresses with [11:10] == 2'b11 are read-only
    function automatic logic is_read_only(input logic [11:0] addr);
        return (addr[11:10] == 2'b11);
    endfunction

endpackage

// File: rtl/csr_trap_ctrl_target.sv
// csr_trap_target: combinational trap target from mtvec and mcause.
// Vectored interrupt dispatch is built only when QT_VECTORED_TRAP_EN is
// defined; otherwise the mode bits are ignored and the base is used.
module csr_trap_target #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] mtvec,
    input  logic [DW-1:0] cause,
    output logic [DW-1:0] target
);

    logic [DW-1:0] base;
    assign base = {mtvec[DW-1:2], 2'b00};

`ifdef QT_VECTORED_TRAP_EN
    // Vectored mode with an interrupt cause jumps to base + 4*cause code
    always_comb begin
        target = base;
        if (mtvec[1:0] == 2'b01 && cause[DW-1])
            target = base + {cause[DW-3:0], 2'b00};
    end
`else
    // Direct mode only: cause and mode bits play no part in the target
    logic unused_inputs;
    assign unused_inputs = ^{cause, mtvec[1:0]};
    assign target = base;
`endif

endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: arbiter/sequencer for the single CSR regfile port.
// Serves pipeline CSR instructions with zero latency and runs the
// multi-cycle trap-entry and mret sequences, each ending in one redirect.
// Optional feature macro: QT_VECTORED_TRAP_EN (vectored interrupt targets).
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter int DW = `REG_WIDTH
) (
    input  logic          clk_sys_i,
    input  logic          rst_sys_n_i,
    input  logic          inst_csr_req_i,
    input  logic [11:0]   inst_csr_addr_i,
    input  logic          inst_csr_we_i,
    input  logic [DW-1:0] inst_csr_wdata_i,
    output logic          inst_csr_gnt_o,
    output logic [DW-1:0] inst_csr_rdata_o,
    output logic          inst_csr_illegal_o,
    input  logic          trap_req_i,
    input  logic [DW-1:0] trap_cause_i,
    input  logic [DW-1:0] trap_pc_i,
    input  logic [DW-1:0] trap_tval_i,
    input  logic          mret_req_i,
    output logic          trap_ack_o,
    output logic          mret_ack_o,
    output logic [11:0]   csr_addr_o,
    output logic          csr_write_ena_o,
    output logic [DW-1:0] csr_wdata_o,
    input  logic [DW-1:0] csr_rdata_i,
    output logic          busy_o,
    output logic          redirect_valid_o,
    output logic [DW-1:0] redirect_pc_o
);

    state_t        state_reg;
    logic [DW-1:0] cause_reg;
    logic [DW-1:0] pc_reg;
    logic [DW-1:0] tval_reg;
    logic [DW-1:0] trap_target;
    logic [DW-1:0] mstatus_trap;
    logic [DW-1:0] mstatus_mret;

    csr_trap_target #(.DW(DW)) u_target (
        .mtvec  (csr_rdata_i),
        .cause  (cause_reg),
        .target (trap_target)
    );

    // mstatus images written during trap entry and mret
    always_comb begin
        mstatus_trap = csr_rdata_i;
        mstatus_trap[MSTATUS_MPIE] = csr_rdata_i[MSTATUS_MIE];
        mstatus_trap[MSTATUS_MIE]  = 1'b0;
        mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_mret = csr_rdata_i;
        mstatus_mret[MSTATUS_MIE]  = csr_rdata_i[MSTATUS_MPIE];
        mstatus_mret[MSTATUS_MPIE] = 1'b1;
        mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    assign inst_csr_rdata_o = csr_rdata_i;
    assign busy_o           = (state_reg != ST_IDLE);

    // Port mux and IDLE arbitration; everything is suppressed while in reset
    // so a reset landing mid-sequence cannot complete the pending write.
    always_comb begin
        trap_ack_o         = 1'b0;
        mret_ack_o         = 1'b0;
        inst_csr_gnt_o     = 1'b0;
        inst_csr_illegal_o = 1'b0;
        csr_addr_o         = inst_csr_addr_i;
        csr_write_ena_o    = 1'b0;
        csr_wdata_o        = inst_csr_wdata_i;
        case (state_reg)
            ST_IDLE: begin
                if (trap_req_i) begin
                    trap_ack_o = 1'b1;
                end else if (mret_req_i) begin
                    mret_ack_o = 1'b1;
                end else if (inst_csr_req_i) begin
                    inst_csr_gnt_o     = 1'b1;
                    csr_write_ena_o    = inst_csr_we_i && !is_read_only(inst_csr_addr_i);
                    inst_csr_illegal_o = inst_csr_we_i && is_read_only(inst_csr_addr_i);
                end
            end
            ST_T_EPC: begin
                csr_addr_o      = CSR_MEPC;
                csr_write_ena_o = 1'b1;
                csr_wdata_o     = {pc_reg[DW-1:2], 2'b00};
            end
            ST_T_CAUSE: begin
                csr_addr_o      = CSR_MCAUSE;
                csr_write_ena_o = 1'b1;
                csr_wdata_o     = cause_reg;
            end
            ST_T_TVAL: begin
                csr_addr_o      = CSR_MTVAL;
                csr_write_ena_o = 1'b1;
                csr_wdata_o     = tval_reg;
            end
            ST_T_STAT: begin
                csr_addr_o      = CSR_MSTATUS;
                csr_write_ena_o = 1'b1;
                csr_wdata_o     = mstatus_trap;
            end
            ST_T_VEC:  csr_addr_o = CSR_MTVEC;
            ST_R_STAT: begin
                csr_addr_o      = CSR_MSTATUS;
                csr_write_ena_o = 1'b1;
                csr_wdata_o     = mstatus_mret;
            end
            ST_R_EPC:  csr_addr_o = CSR_MEPC;
            default: ;
        endcase
        if (!rst_sys_n_i) begin
            trap_ack_o         = 1'b0;
            mret_ack_o         = 1'b0;
            inst_csr_gnt_o     = 1'b0;
            inst_csr_illegal_o = 1'b0;
            csr_write_ena_o    = 1'b0;
        end
    end

    // Sequencer state, trap payload capture and registered redirect
    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_n_i) begin
            state_reg        <= ST_IDLE;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            cause_reg        <= '0;
            pc_reg           <= '0;
            tval_reg         <= '0;
        end else begin
            redirect_valid_o <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (trap_req_i) begin
                        state_reg <= ST_T_EPC;
                        cause_reg <= trap_cause_i;
                        pc_reg    <= trap_pc_i;
                        tval_reg  <= trap_tval_i;
                    end else if (mret_req_i) begin
                        state_reg <= ST_R_STAT;
                    end
                end
                ST_T_EPC:   state_reg <= ST_T_CAUSE;
                ST_T_CAUSE: state_reg <= ST_T_TVAL;
                ST_T_TVAL:  state_reg <= ST_T_STAT;
                ST_T_STAT:  state_reg <= ST_T_VEC;
                ST_T_VEC: begin
                    state_reg        <= ST_IDLE;
                    redirect_valid_o <= 1'b1;
                    redirect_pc_o    <= trap_target;
                end
                ST_R_STAT:  state_reg <= ST_R_EPC;
                ST_R_EPC: begin
                    state_reg        <= ST_IDLE;
                    redirect_valid_o <= 1'b1;
                    redirect_pc_o    <= csr_rdata_i;
                end
                default:    state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: directed bench for csr_trap_ctrl with a behavioural
// CSR register file. Instruction accesses are table driven; trap, mret,
// arbitration and mid-sequence reset are hand-written sequences.
module tb_csr_trap_ctrl;

    localparam int DW = 32;

`ifdef QT_VECTORED_TRAP_EN
    localparam logic [31:0] EXP_VEC_TARGET = 32'h0000_021C;
`else
    localparam logic [31:0] EXP_VEC_TARGET = 32'h0000_0200;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_req, inst_we;
    logic [11:0]   inst_addr;
    logic [31:0]   inst_wdata;
    logic          inst_gnt, inst_illegal;
    logic [31:0]   inst_rdata;
    logic          trap_req, mret_req;
    logic [31:0]   trap_cause, trap_pc, trap_tval;
    logic          trap_ack, mret_ack;
    logic [11:0]   csr_addr;
    logic          csr_we;
    logic [31:0]   csr_wdata, csr_rdata;
    logic          busy, redirect_valid;
    logic [31:0]   redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csr_trap_ctrl #(.DW(DW)) dut (
        .clk_sys_i          (clk),
        .rst_sys_n_i        (rst_n),
        .inst_csr_req_i     (inst_req),
        .inst_csr_addr_i    (inst_addr),
        .inst_csr_we_i      (inst_we),
        .inst_csr_wdata_i   (inst_wdata),
        .inst_csr_gnt_o     (inst_gnt),
        .inst_csr_rdata_o   (inst_rdata),
        .inst_csr_illegal_o (inst_illegal),
        .trap_req_i         (trap_req),
        .trap_cause_i       (trap_cause),
        .trap_pc_i          (trap_pc),
        .trap_tval_i        (trap_tval),
        .mret_req_i         (mret_req),
        .trap_ack_o         (trap_ack),
        .mret_ack_o         (mret_ack),
        .csr_addr_o         (csr_addr),
        .csr_write_ena_o    (csr_we),
        .csr_wdata_o        (csr_wdata),
        .csr_rdata_i        (csr_rdata),
        .busy_o             (busy),
        .redirect_valid_o   (redirect_valid),
        .redirect_pc_o      (redirect_pc)
    );

    // Behavioural regfile: combinational read, mhartid (0xF14) reads 5
    logic [31:0] regs [0:4095] = '{default: 32'h0};
    assign csr_rdata = (csr_addr == 12'hF14) ? 32'h5 : regs[csr_addr];
    always @(posedge clk) if (csr_we) regs[csr_addr] <= csr_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [8];
    int   cyc;
    logic seen;

    initial begin
        vecs[0] = '{12'h341, 1'b1, 32'h80,  32'h0,   1'b0};
        vecs[1] = '{12'h341, 1'b0, 32'h0,   32'h80,  1'b0};
        vecs[2] = '{12'hF14, 1'b1, 32'h77,  32'h5,   1'b1};
        vecs[3] = '{12'hF14, 1'b0, 32'h0,   32'h5,   1'b0};
        vecs[4] = '{12'h305, 1'b1, 32'h100, 32'h0,   1'b0};
        vecs[5] = '{12'h300, 1'b1, 32'h8,   32'h0,   1'b0};
        vecs[6] = '{12'h300, 1'b0, 32'h0,   32'h8,   1'b0};
        vecs[7] = '{12'h305, 1'b0, 32'h0,   32'h100, 1'b0};

        rst_n = 1'b0; inst_req = 0; inst_we = 0; inst_addr = 0; inst_wdata = 0;
        trap_req = 0; mret_req = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_redirect_valid", {31'b0, redirect_valid}, 0);
        check("reset_redirect_pc", redirect_pc, 0);
        check("reset_we", {31'b0, csr_we}, 0);
        rst_n = 1'b1;

        // Table-driven instruction accesses
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            inst_req = 1; inst_addr = vecs[i].addr; inst_we = vecs[i].we; inst_wdata = vecs[i].wdata;
            #1;
            $display("inst vec %0d addr=%h we=%0d wdata=%h -> gnt=%0d rdata=%h ill=%0d",
                     i, inst_addr, inst_we, inst_wdata, inst_gnt, inst_rdata, inst_illegal);
            check("inst_gnt", {31'b0, inst_gnt}, 1);
            check("inst_rdata", inst_rdata, vecs[i].exp_rdata);
            check("inst_illegal", {31'b0, inst_illegal}, {31'b0, vecs[i].exp_ill});
            check("inst_write_ena", {31'b0, csr_we}, {31'b0, vecs[i].we & ~vecs[i].exp_ill});
            @(posedge clk); #1;
            inst_req = 0; inst_we = 0;
        end
        check("mepc_after_write", regs[12'h341], 32'h80);
        check("f14_not_written", regs[12'hF14], 32'h0);

        // Trap entry: cause 2, pc 0x1002, tval 0xDEAD, mtvec 0x100, MIE=1
        @(negedge clk);
        trap_req = 1; trap_cause = 32'h2; trap_pc = 32'h1002; trap_tval = 32'hDEAD;
        #1;
        check("trap_ack", {31'b0, trap_ack}, 1);
        @(posedge clk); #1;
        trap_req = 0;
        check("trap_busy_c1", {31'b0, busy}, 1);
        cyc = 1;
        while (!redirect_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        $display("trap redirect cycle=%0d pc=%h", cyc, redirect_pc);
        check("trap_redirect_cycle", cyc, 6);
        check("trap_redirect_pc", redirect_pc, 32'h100);
        check("trap_idle_at_redirect", {31'b0, busy}, 0);
        check("mepc", regs[12'h341], 32'h1000);
        check("mcause", regs[12'h342], 32'h2);
        check("mtval", regs[12'h343], 32'hDEAD);
        check("mstatus_trap", regs[12'h300], 32'h1880);
        @(posedge clk); #1;
        check("redirect_one_cycle", {31'b0, redirect_valid}, 0);
        check("redirect_pc_holds", redirect_pc, 32'h100);

        // mret after the trap
        @(negedge clk);
        mret_req = 1;
        #1;
        check("mret_ack", {31'b0, mret_ack}, 1);
        @(posedge clk); #1;
        mret_req = 0;
        cyc = 1;
        while (!redirect_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        $display("mret redirect cycle=%0d pc=%h", cyc, redirect_pc);
        check("mret_redirect_cycle", cyc, 3);
        check("mret_redirect_pc", redirect_pc, 32'h1000);
        check("mstatus_mret", regs[12'h300], 32'h1888);

        // Set vectored mtvec, then simultaneous trap/mret/instruction
        @(negedge clk);
        inst_req = 1; inst_addr = 12'h305; inst_we = 1; inst_wdata = 32'h201;
        @(posedge clk); #1;
        inst_req = 0; inst_we = 0;
        @(negedge clk);
        trap_req = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h3000; trap_tval = 32'h0;
        mret_req = 1; inst_req = 1; inst_addr = 12'h342; inst_we = 0;
        #1;
        check("arb_trap_ack", {31'b0, trap_ack}, 1);
        check("arb_mret_ack", {31'b0, mret_ack}, 0);
        check("arb_gnt", {31'b0, inst_gnt}, 0);
        @(posedge clk); #1;
        trap_req = 0;
        cyc = 1; seen = 0;
        while (!mret_ack && cyc < 20) begin
            if (inst_gnt) seen = 1;
            @(posedge clk); #1; cyc++;
        end
        $display("arb mret_ack cycle=%0d redirect=%0d pc=%h", cyc, redirect_valid, redirect_pc);
        check("arb_mret_ack_cycle", cyc, 6);
        check("arb_no_early_gnt", {31'b0, seen | inst_gnt}, 0);
        check("vec_redirect_valid", {31'b0, redirect_valid}, 1);
        check("vec_redirect_pc", redirect_pc, EXP_VEC_TARGET);
        @(posedge clk); #1;
        mret_req = 0;
        cyc = 1;
        while (!inst_gnt && cyc < 20) begin @(posedge clk); #1; cyc++; end
        $display("arb inst gnt cycle=%0d rdata=%h redirect_pc=%h", cyc, inst_rdata, redirect_pc);
        check("arb_gnt_cycle", cyc, 3);
        check("arb_gnt_rdata", inst_rdata, 32'h8000_0007);
        check("arb_mret_redirect_pc", redirect_pc, 32'h3000);
        @(posedge clk); #1;
        inst_req = 0;

        // Reset in T_TVAL: earlier writes stay, mtval untouched, no redirect
        @(negedge clk);
        trap_req = 1; trap_cause = 32'h5; trap_pc = 32'h2000; trap_tval = 32'h1234;
        @(posedge clk); #1;
        trap_req = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_busy_c3", {31'b0, busy}, 1);
        rst_n = 0;
        #1;
        check("rst_mid_no_write", {31'b0, csr_we}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        check("rst_mid_idle", {31'b0, busy}, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (redirect_valid) seen = 1;
            @(posedge clk); #1;
        end
        $display("rst_mid mepc=%h mcause=%h mtval=%h", regs[12'h341], regs[12'h342], regs[12'h343]);
        check("rst_mid_no_redirect", {31'b0, seen}, 0);
        check("rst_mid_redirect_pc", redirect_pc, 0);
        check("rst_mid_mepc", regs[12'h341], 32'h2000);
        check("rst_mid_mcause", regs[12'h342], 32'h5);
        check("rst_mid_mtval", regs[12'h343], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
